// File: rtl/bf_program_loader.sv
// Brainfuck program loader: encodes an ASCII source stream into 3-bit opcodes,
// writes them to program memory from address 0, checks bracket balance,
// zero-fills the rest of memory and holds the core until a clean load completes.
module bf_program_loader #(
  parameter int PRG_AW   = 8,
  parameter int INSTR_W  = 3,
  parameter int STACK_AW = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte_data,
  input  logic               i_byte_last,
  output logic               o_byte_ready,
  output logic               o_prgmem_in,
  output logic [PRG_AW-1:0]  o_prgmem_addr,
  output logic [INSTR_W-1:0] o_prgmem_data,
  output logic               o_cpu_hold,
  output logic               o_done,
  output logic               o_error,
  output logic [1:0]         o_err_code,
  output logic [PRG_AW:0]    o_length
);

  localparam int              DEPTH_W   = STACK_AW + 1;
  localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'((1 << STACK_AW) - 1);
  localparam logic [PRG_AW:0] PRG_SIZE  = (PRG_AW+1)'(1 << PRG_AW);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_DONE, S_ERROR} state_t;

  state_t               state;
  logic [PRG_AW:0]      count;      // opcodes written so far, also next write address
  logic [PRG_AW:0]      fill_addr;  // next zero-fill address; reaching PRG_SIZE ends FILL
  logic [DEPTH_W-1:0]   depth;      // current bracket nesting

  logic [INSTR_W-1:0]   op;
  logic                 is_op, is_open, is_close, accept;
  logic                 err_close, err_open, err_len;
  logic [DEPTH_W-1:0]   depth_nxt;
  logic [PRG_AW:0]      count_nxt;

  // Byte decode: opcode, bracket direction and the three abort conditions
  always_comb begin
    op = '0;
    case (i_byte_data)
      8'h2B:   op = INSTR_W'(3'b010); // +
      8'h2D:   op = INSTR_W'(3'b011); // -
      8'h3E:   op = INSTR_W'(3'b100); // >
      8'h3C:   op = INSTR_W'(3'b101); // <
      8'h5B:   op = INSTR_W'(3'b110); // [
      8'h5D:   op = INSTR_W'(3'b111); // ]
      default: op = '0;               // comment byte
    endcase
    is_op     = (op != '0);
    is_open   = (i_byte_data == 8'h5B);
    is_close  = (i_byte_data == 8'h5D);
    accept    = i_byte_valid && o_byte_ready;
    err_close = is_close && (depth == '0);
    err_open  = is_open && (depth == MAX_DEPTH);
    err_len   = is_op && (count == PRG_SIZE);
    depth_nxt = depth + DEPTH_W'(is_open) - DEPTH_W'(is_close);
    count_nxt = count + (PRG_AW+1)'(is_op);
  end

  assign o_length = count;

  // Load FSM with registered memory-write port and status outputs.
  // FILL lingers one extra cycle so its final write is still presented
  // while the state is FILL; DONE follows once every address is written.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      count         <= '0;
      fill_addr     <= '0;
      depth         <= '0;
      o_byte_ready  <= 1'b0;
      o_prgmem_in   <= 1'b0;
      o_prgmem_addr <= '0;
      o_prgmem_data <= '0;
      o_cpu_hold    <= 1'b1;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_err_code    <= 2'b00;
    end else begin
      o_prgmem_in <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            state        <= S_LOAD;
            count        <= '0;
            depth        <= '0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_err_code   <= 2'b00;
            o_cpu_hold   <= 1'b1;
            o_byte_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (err_close || err_open || err_len) begin
              state        <= S_ERROR;
              o_error      <= 1'b1;
              o_byte_ready <= 1'b0;
              o_err_code   <= err_close ? 2'b01 : (err_open ? 2'b10 : 2'b11);
            end else begin
              if (is_op) begin
                o_prgmem_in   <= 1'b1;
                o_prgmem_addr <= count[PRG_AW-1:0];
                o_prgmem_data <= op;
              end
              count <= count_nxt;
              depth <= depth_nxt;
              if (i_byte_last) begin
                o_byte_ready <= 1'b0;
                if (depth_nxt != '0) begin
                  state      <= S_ERROR;
                  o_error    <= 1'b1;
                  o_err_code <= 2'b01;
                end else if (count_nxt == PRG_SIZE) begin
                  state      <= S_DONE;
                  o_done     <= 1'b1;
                  o_cpu_hold <= 1'b0;
                end else begin
                  state     <= S_FILL;
                  fill_addr <= count_nxt;
                end
              end
            end
          end
        end
        S_FILL: begin
          if (fill_addr == PRG_SIZE) begin
            state      <= S_DONE;
            o_done     <= 1'b1;
            o_cpu_hold <= 1'b0;
          end else begin
            o_prgmem_in   <= 1'b1;
            o_prgmem_addr <= fill_addr[PRG_AW-1:0];
            o_prgmem_data <= '0;
            fill_addr     <= fill_addr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_program_loader.sv
// Bench for bf_program_loader: a source-level model predicts every memory write
// and the final status; a monitor checks each write as it appears.
module tb_bf_program_loader;

  logic       i_clock = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_byte_valid = 1'b0;
  logic [7:0] i_byte_data = 8'h00;
  logic       i_byte_last = 1'b0;
  logic       o_byte_ready, o_prgmem_in, o_cpu_hold, o_done, o_error;
  logic [7:0] o_prgmem_addr;
  logic [2:0] o_prgmem_data;
  logic [1:0] o_err_code;
  logic [8:0] o_length;

  bf_program_loader dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_start(i_start),
    .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data), .i_byte_last(i_byte_last),
    .o_byte_ready(o_byte_ready), .o_prgmem_in(o_prgmem_in),
    .o_prgmem_addr(o_prgmem_addr), .o_prgmem_data(o_prgmem_data),
    .o_cpu_hold(o_cpu_hold), .o_done(o_done), .o_error(o_error),
    .o_err_code(o_err_code), .o_length(o_length)
  );

  always #5 i_clock = ~i_clock;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct packed { logic [7:0] addr; logic [2:0] data; } wr_t;
  wr_t exp_q[$];
  int  exp_len, exp_err, exp_done;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int enc(input byte c);
    case (c)
      "+": return 2; "-": return 3; ">": return 4;
      "<": return 5; "[": return 6; "]": return 7;
      default: return 0;
    endcase
  endfunction

  // Source-level model: walk the text, list the writes and the outcome
  task automatic model(input string s);
    int d, cnt, op;
    d = 0; cnt = 0; exp_err = 0; exp_done = 0;
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      op = enc(s[i]);
      if (op != 0) begin
        if (op == 7 && d == 0)  begin exp_err = 1; break; end
        if (op == 6 && d == 15) begin exp_err = 2; break; end
        if (cnt == 256)         begin exp_err = 3; break; end
        exp_q.push_back({8'(cnt), 3'(op)});
        cnt++;
        if (op == 6) d++;
        if (op == 7) d--;
      end
      if (i == s.len() - 1) begin
        if (d != 0) exp_err = 1;
        else begin
          for (int a = cnt; a < 256; a++) exp_q.push_back({8'(a), 3'b000});
          exp_done = 1;
        end
      end
    end
    exp_len = cnt;
  endtask

  // Every presented write must be the next one the model predicts
  always @(negedge i_clock) begin
    if (o_prgmem_in) begin
      if (exp_q.size() == 0) check("unexpected_write_pending", exp_q.size(), 1);
      else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", int'(o_prgmem_addr), int'(w.addr));
        check("wr_data", int'(o_prgmem_data), int'(w.data));
      end
    end
  end

  task automatic start_load(input string name);
    @(negedge i_clock);
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    check({name, "_hold_on_start"}, int'(o_cpu_hold), 1);
    check({name, "_done_cleared"}, int'(o_done), 0);
    check({name, "_ready"}, int'(o_byte_ready), 1);
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (!o_byte_ready) break;
      i_byte_valid = 1'b1;
      i_byte_data  = s[i];
      i_byte_last  = (i == s.len() - 1);
      @(negedge i_clock);
    end
    i_byte_valid = 1'b0;
    i_byte_last  = 1'b0;
  endtask

  task automatic run(input string name, input string s, input int lit_len,
                     input int lit_err, input int lit_done);
    model(s);
    check({name, "_model_len"}, exp_len, lit_len);
    check({name, "_model_err"}, exp_err, lit_err);
    start_load(name);
    feed(s);
    for (int c = 0; c < 400 && !(o_done || o_error); c++) @(negedge i_clock);
    check({name, "_finished"}, int'(o_done || o_error), 1);
    repeat (3) @(negedge i_clock);
    check({name, "_writes_left"}, exp_q.size(), 0);
    check({name, "_done"}, int'(o_done), exp_done);
    check({name, "_error"}, int'(o_error), exp_err != 0 ? 1 : 0);
    check({name, "_err_code"}, int'(o_err_code), exp_err);
    check({name, "_err_code_lit"}, int'(o_err_code), lit_err);
    check({name, "_length"}, int'(o_length), exp_len);
    check({name, "_length_lit"}, int'(o_length), lit_len);
    check({name, "_hold"}, int'(o_cpu_hold), lit_done ? 0 : 1);
    check({name, "_ready_off"}, int'(o_byte_ready), 0);
  endtask

  initial begin
    string s;
    repeat (2) @(negedge i_clock);
    check("rst_hold", int'(o_cpu_hold), 1);
    check("rst_ready", int'(o_byte_ready), 0);
    check("rst_wr", int'(o_prgmem_in), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_error", int'(o_error), 0);
    check("rst_len", int'(o_length), 0);
    i_reset_n = 1'b1;

    run("loop", "+[->+<]", 7, 0, 1);
    run("comment", "a+ b\n", 1, 0, 1);
    run("unbal_close", "+]", 1, 1, 0);
    s = "";
    for (int i = 0; i < 16; i++) s = {s, "["};
    run("too_deep", s, 15, 2, 0);
    run("open_last", "[[", 2, 1, 0);
    s = "";
    for (int i = 0; i < 257; i++) s = {s, "+"};
    run("too_long", s, 256, 3, 0);
    s = "";
    for (int i = 0; i < 256; i++) s = {s, "+"};
    run("full", s, 256, 0, 1);

    // Reset in the middle of FILL aborts at once
    model("+");
    start_load("rst_fill");
    feed("+");
    repeat (6) @(negedge i_clock);
    @(posedge i_clock);
    #2 i_reset_n = 1'b0;
    #1;
    check("rstfill_wr", int'(o_prgmem_in), 0);
    check("rstfill_hold", int'(o_cpu_hold), 1);
    check("rstfill_done", int'(o_done), 0);
    check("rstfill_len", int'(o_length), 0);
    exp_q.delete();
    @(negedge i_clock);
    @(negedge i_clock);
    check("rstfill_wr_held", int'(o_prgmem_in), 0);
    i_reset_n = 1'b1;
    run("reload", "+[->+<]", 7, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
